// File: rtl/usb_token_tx_ctrl.sv
// USB token packet transmit sequencer: serialises PID, ADDR/ENDP and CRC-5 bits
// while steering an external serial CRC-5 datapath.
module usb_token_tx_ctrl (
    input  logic       clk_c,
    input  logic       reset,
    input  logic       tok_valid,
    output logic       tok_ready,
    input  logic [3:0] tok_pid,
    input  logic [6:0] tok_addr,
    input  logic [3:0] tok_endp,
    input  logic       tx_hold,
    input  logic       tx_abort,
    output logic       crc_rst,
    output logic       crc_cwe_z,
    output logic       crc_halt,
    output logic       crc_din,
    input  logic       crc_dout,
    output logic       tx_bit,
    output logic       tx_bit_valid,
    output logic       tx_last,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PID   = 3'd2,
        FIELD = 3'd3,
        CRC   = 3'd4
    } state_t;

    localparam logic [3:0] PID_LAST   = 4'd7;
    localparam logic [3:0] FIELD_LAST = 4'd10;
    localparam logic [3:0] CRC_LAST   = 4'd4;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [7:0]  pid_byte;
    logic [10:0] field_bits;

    always_ff @(posedge clk_c or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            pid_byte   <= 8'd0;
            field_bits <= 11'd0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= 4'd0;
                    if (tok_valid) begin
                        pid_byte   <= {~tok_pid, tok_pid};
                        field_bits <= {tok_endp, tok_addr};
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    bit_cnt <= 4'd0;
                    state   <= tx_abort ? IDLE : PID;
                end
                PID: begin
                    if (tx_abort) begin
                        state   <= IDLE;
                        bit_cnt <= 4'd0;
                    end else if (!tx_hold) begin
                        if (bit_cnt == PID_LAST) begin
                            state   <= FIELD;
                            bit_cnt <= 4'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                FIELD: begin
                    if (tx_abort) begin
                        state   <= IDLE;
                        bit_cnt <= 4'd0;
                    end else if (!tx_hold) begin
                        if (bit_cnt == FIELD_LAST) begin
                            state   <= CRC;
                            bit_cnt <= 4'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                CRC: begin
                    if (tx_abort) begin
                        state   <= IDLE;
                        bit_cnt <= 4'd0;
                    end else if (!tx_hold) begin
                        if (bit_cnt == CRC_LAST) begin
                            state   <= IDLE;
                            bit_cnt <= 4'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= 4'd0;
                end
            endcase
        end
    end

    // The CRC datapath only runs in FIELD/CRC; it is held in reset while idle
    // and during the abort cycle so a stale remainder never leaks into a token.
    always_comb begin
        tok_ready    = 1'b0;
        busy         = 1'b1;
        crc_rst      = 1'b0;
        crc_cwe_z    = 1'b0;
        crc_halt     = 1'b1;
        crc_din      = 1'b0;
        tx_bit       = 1'b0;
        tx_bit_valid = 1'b0;
        tx_last      = 1'b0;
        case (state)
            IDLE: begin
                tok_ready = 1'b1;
                busy      = 1'b0;
                crc_rst   = 1'b1;
            end
            LOAD: begin
                crc_rst = 1'b1;
            end
            PID: begin
                crc_rst      = tx_abort;
                tx_bit       = pid_byte[bit_cnt[2:0]];
                tx_bit_valid = 1'b1;
            end
            FIELD: begin
                crc_rst      = tx_abort;
                crc_cwe_z    = 1'b1;
                crc_halt     = tx_hold;
                crc_din      = field_bits[bit_cnt];
                tx_bit       = crc_dout;
                tx_bit_valid = 1'b1;
            end
            CRC: begin
                crc_rst      = tx_abort;
                crc_halt     = tx_hold;
                tx_bit       = crc_dout;
                tx_bit_valid = 1'b1;
                tx_last      = (bit_cnt == CRC_LAST) && !tx_abort;
            end
            default: begin
                crc_rst = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_token_tx_ctrl.sv
// Directed bench for usb_token_tx_ctrl with a behavioural CRC-5 datapath and
// a bit-level scoreboard of the expected line bits.
module tb_usb_token_tx_ctrl;

    logic       clk_c = 1'b0;
    logic       reset;
    logic       tok_valid;
    logic       tok_ready;
    logic [3:0] tok_pid;
    logic [6:0] tok_addr;
    logic [3:0] tok_endp;
    logic       tx_hold;
    logic       tx_abort;
    logic       crc_rst;
    logic       crc_cwe_z;
    logic       crc_halt;
    logic       crc_din;
    logic       crc_dout;
    logic       tx_bit;
    logic       tx_bit_valid;
    logic       tx_last;
    logic       busy;

    usb_token_tx_ctrl dut (
        .clk_c        (clk_c),
        .reset        (reset),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_pid      (tok_pid),
        .tok_addr     (tok_addr),
        .tok_endp     (tok_endp),
        .tx_hold      (tx_hold),
        .tx_abort     (tx_abort),
        .crc_rst      (crc_rst),
        .crc_cwe_z    (crc_cwe_z),
        .crc_halt     (crc_halt),
        .crc_din      (crc_din),
        .crc_dout     (crc_dout),
        .tx_bit       (tx_bit),
        .tx_bit_valid (tx_bit_valid),
        .tx_last      (tx_last),
        .busy         (busy)
    );

    always #5 clk_c = ~clk_c;

    // USB CRC-5 serial datapath (x^5+x^2+1, preset ones, inverted readout MSB first)
    logic [4:0] crc_r = 5'h1f;
    always @(posedge clk_c) begin
        if (crc_rst)
            crc_r <= 5'h1f;
        else if (!crc_halt) begin
            if (crc_cwe_z)
                crc_r <= {crc_r[3:0], 1'b0} ^ (((crc_din ^ crc_r[4]) == 1'b1) ? 5'h05 : 5'h00);
            else
                crc_r <= {crc_r[3:0], 1'b1};
        end
    end
    assign crc_dout = crc_cwe_z ? crc_din : ~crc_r[4];

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   n_last = 0;
    int   n_bits = 0;
    int   last_cyc = 0;
    int   hs = 0;
    int   nl0 = 0;
    int   nb0 = 0;
    logic hold_prev = 1'b0;
    logic prev_bit  = 1'b0;
    exp_t e_mon;

    always @(posedge clk_c) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Expected line bits: PID byte LSB first, addr/endp LSB first, CRC MSB first
    task automatic push_tok(input logic [3:0] pid, input logic [6:0] addr,
                            input logic [3:0] endp, input logic [4:0] crc, input int nbits);
        logic [7:0]  pb;
        logic [10:0] fb;
        logic [23:0] seq;
        pb = {~pid, pid};
        fb = {endp, addr};
        for (int i = 0; i < 8; i++)  seq[i] = pb[i];
        for (int i = 0; i < 11; i++) seq[8 + i] = fb[i];
        for (int i = 0; i < 5; i++)  seq[19 + i] = crc[4 - i];
        for (int i = 0; i < nbits; i++) sb.push_back('{b: seq[i], last: (i == 23)});
    endtask

    always @(negedge clk_c) begin
        if (hold_prev)
            check("hold_stable", tx_bit, prev_bit);
        hold_prev = !reset && tx_hold && tx_bit_valid && !tx_abort;
        prev_bit  = tx_bit;
        if (!reset && tx_bit_valid && !tx_hold && !tx_abort) begin
            check("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e_mon = sb.pop_front();
                check("line_bit", tx_bit, e_mon.b);
                check("last_flag", tx_last, e_mon.last);
            end
            n_bits++;
            if (tx_last) begin
                n_last++;
                last_cyc = cyc;
            end
        end
    end

    function automatic logic [8:0] outs9();
        return {tok_ready, busy, crc_rst, crc_halt, crc_cwe_z, crc_din, tx_bit, tx_bit_valid, tx_last};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_c);
        #1;
    endtask

    task automatic send(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
        tok_pid   = pid;
        tok_addr  = addr;
        tok_endp  = endp;
        tok_valid = 1'b1;
        hs  = cyc;
        nl0 = n_last;
        nb0 = n_bits;
        tick(1);
        tok_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick(1);
            n++;
        end
        check({tag, "_idle_timeout"}, busy, 0);
    endtask

    task automatic post(input string tag, input int lat);
        wait_idle(tag);
        check({tag, "_lat"}, last_cyc - hs, lat);
        check({tag, "_nlast"}, n_last - nl0, 1);
        check({tag, "_nbits"}, n_bits - nb0, 24);
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; tok_valid = 1'b0; tok_pid = '0; tok_addr = '0; tok_endp = '0;
        tx_hold = 1'b0; tx_abort = 1'b0;
        #1 reset = 1'b1;
        #1 check("rst_async_outs", outs9(), 9'b1_0_1_1_0_0_0_0_0);
        tick(3);
        check("rst_outs", outs9(), 9'b1_0_1_1_0_0_0_0_0);
        reset = 1'b0;
        tick(2);

        // SETUP token, exact latency points
        push_tok(4'hD, 7'h15, 4'hE, 5'h17, 24);
        send(4'hD, 7'h15, 4'hE);
        check("setup_load_ready", tok_ready, 0);
        tick(24);
        check("setup_last_c25", tx_last, 1);
        check("setup_ready_c25", tok_ready, 0);
        tick(1);
        check("setup_ready_c26", tok_ready, 1);
        post("setup", 25);

        // OUT token
        push_tok(4'h1, 7'h3A, 4'hA, 5'h1C, 24);
        send(4'h1, 7'h3A, 4'hA);
        post("out", 25);

        // IN token with holds mid-FIELD and mid-CRC
        push_tok(4'h9, 7'h70, 4'h4, 5'h0E, 24);
        send(4'h9, 7'h70, 4'h4);
        tick(12);
        tx_hold = 1'b1;
        #1 check("in_halt_field", crc_halt, 1);
        tick(3);
        tx_hold = 1'b0;
        #1 check("in_run_field", crc_halt, 0);
        tick(10);
        tx_hold = 1'b1;
        #1 check("in_halt_crc", crc_halt, 1);
        tick(2);
        tx_hold = 1'b0;
        post("in_hold", 30);

        // abort (with hold) in FIELD bit 5
        push_tok(4'h1, 7'h3A, 4'hA, 5'h1C, 13);
        send(4'h1, 7'h3A, 4'hA);
        tick(14);
        tx_abort = 1'b1;
        tx_hold  = 1'b1;
        #1 check("abort_crc_rst", crc_rst, 1);
        check("abort_no_last", tx_last, 0);
        tick(1);
        tx_abort = 1'b0;
        tx_hold  = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_ready", tok_ready, 1);
        check("abort_nbits", n_bits - nb0, 13);
        check("abort_nlast", n_last - nl0, 0);
        check("abort_sb_empty", sb.size(), 0);
        push_tok(4'hD, 7'h15, 4'hE, 5'h17, 24);
        send(4'hD, 7'h15, 4'hE);
        post("after_abort", 25);

        // abort in IDLE is ignored and the token is still accepted
        push_tok(4'h9, 7'h3A, 4'hA, 5'h1C, 24);
        tx_abort = 1'b1;
        send(4'h9, 7'h3A, 4'hA);
        tx_abort = 1'b0;
        check("idle_abort_accept", busy, 1);
        post("idle_abort", 25);

        // async reset mid-PID
        push_tok(4'hD, 7'h15, 4'hE, 5'h17, 2);
        send(4'hD, 7'h15, 4'hE);
        tick(3);
        #2 reset = 1'b1;
        #1 check("midpid_rst_outs", outs9(), 9'b1_0_1_1_0_0_0_0_0);
        tick(2);
        reset = 1'b0;
        check("midpid_nbits", n_bits - nb0, 2);
        check("midpid_nlast", n_last - nl0, 0);
        check("midpid_sb_empty", sb.size(), 0);
        tick(1);
        push_tok(4'hD, 7'h15, 4'hE, 5'h17, 24);
        send(4'hD, 7'h15, 4'hE);
        post("after_reset", 25);

        // tok_valid held during busy with changing inputs
        push_tok(4'h9, 7'h70, 4'h4, 5'h0E, 24);
        tok_pid = 4'h9; tok_addr = 7'h70; tok_endp = 4'h4;
        tok_valid = 1'b1;
        hs = cyc; nl0 = n_last; nb0 = n_bits;
        tick(1);
        tok_pid = 4'hD; tok_addr = 7'h15; tok_endp = 4'hE;
        tick(19);
        check("hold_valid_busy", busy, 1);
        tok_valid = 1'b0;
        post("captured", 25);
        tick(5);
        check("no_requeue_busy", busy, 0);
        check("no_requeue_nlast", n_last - nl0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
